match_scoreboard: RTL

MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

---
 rtl/match_scoreboard.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/match_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : match_scoreboard                                       |
// | Description : Multi-player series scoreboard. Counts rising edges of |
// |               per-player game-won levels into saturating scores,     |
// |               detects the series end at WIN_TARGET and reports the   |
// |               current unique leader.                                 |
// |               Optional draw counter: define SCOREBOARD_DRAW_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module match_scoreboard #(
  parameter int N_PLAYERS  = 2,
  parameter int SCORE_W    = 6,
  parameter int WIN_TARGET = 5,
  localparam int IDX_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PLAYERS-1:0]           inc,
  input  logic                           draw_inc,
  input  logic                           clear,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic [IDX_W-1:0]               leader,
  output logic                           leader_valid,
  output logic                           match_over,
  output logic [IDX_W-1:0]               winner,
  output logic                           tie_finish
`ifdef SCOREBOARD_DRAW_EN
  ,
  output logic [SCORE_W-1:0]             draws
`endif
);

  localparam logic [SCORE_W-1:0] c_score_max = '1;

  logic [N_PLAYERS-1:0]         inc_q, inc_d;
  logic [N_PLAYERS*SCORE_W-1:0] score_q, score_d;
  logic                         match_over_q, match_over_d;
  logic [IDX_W-1:0]             winner_q, winner_d;
  logic                         tie_finish_q, tie_finish_d;

  logic [N_PLAYERS-1:0]         w_rise;
  logic                         w_any_hit;
  logic                         w_multi_hit;
  logic [IDX_W-1:0]             w_hit_idx;
  logic [SCORE_W-1:0]           w_top;
  logic [IDX_W-1:0]             w_top_idx;
  logic                         w_top_shared;

  // Edge detect, saturating score update and series-end detection
  always_comb begin
    inc_d        = inc;
    w_rise       = inc & ~inc_q;
    score_d      = score_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;
    tie_finish_d = tie_finish_q;
    w_any_hit    = 1'b0;
    w_multi_hit  = 1'b0;
    w_hit_idx    = '0;
    if (clear) begin
      score_d      = '0;
      match_over_d = 1'b0;
      winner_d     = '0;
      tie_finish_d = 1'b0;
    end else if (!match_over_q) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (w_rise[i] && (score_q[i*SCORE_W +: SCORE_W] != c_score_max)) begin
          score_d[i*SCORE_W +: SCORE_W] = score_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        end
      end
      if (WIN_TARGET != 0) begin
        // Walk downwards so the lowest hitting index is the one kept
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
          if (32'(score_d[i*SCORE_W +: SCORE_W]) == 32'(WIN_TARGET)) begin
            if (w_any_hit) begin
              w_multi_hit = 1'b1;
            end
            w_any_hit = 1'b1;
            w_hit_idx = IDX_W'(i);
          end
        end
        if (w_any_hit) begin
          match_over_d = 1'b1;
          winner_d     = w_hit_idx;
          tie_finish_d = w_multi_hit;
        end
      end
    end
  end

  // Leader is the strictly highest score, derived straight from the registers
  always_comb begin
    w_top        = score_q[0 +: SCORE_W];
    w_top_idx    = '0;
    w_top_shared = 1'b0;
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (score_q[i*SCORE_W +: SCORE_W] > w_top) begin
        w_top        = score_q[i*SCORE_W +: SCORE_W];
        w_top_idx    = IDX_W'(i);
        w_top_shared = 1'b0;
      end else if (score_q[i*SCORE_W +: SCORE_W] == w_top) begin
        w_top_shared = 1'b1;
      end
    end
    leader_valid = !w_top_shared;
    leader       = w_top_shared ? '0 : w_top_idx;
  end

  // Inputs captured as all-ones in reset so levels already high never count
  always_ff @(posedge clk) begin
    if (!reset) begin
      inc_q        <= '1;
      score_q      <= '0;
      match_over_q <= 1'b0;
      winner_q     <= '0;
      tie_finish_q <= 1'b0;
    end else begin
      inc_q        <= inc_d;
      score_q      <= score_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
      tie_finish_q <= tie_finish_d;
    end
  end

  assign score      = score_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;
  assign tie_finish = tie_finish_q;

`ifdef SCOREBOARD_DRAW_EN
  logic               draw_q, draw_d;
  logic [SCORE_W-1:0] draws_q, draws_d;

  // Draw counter: same edge, saturation and freeze behaviour as the scores
  always_comb begin
    draw_d  = draw_inc;
    draws_d = draws_q;
    if (clear) begin
      draws_d = '0;
    end else if (!match_over_q && draw_inc && !draw_q && (draws_q != c_score_max)) begin
      draws_d = draws_q + SCORE_W'(1);
    end
  end

  // Draw edge register and counter state
  always_ff @(posedge clk) begin
    if (!reset) begin
      draw_q  <= 1'b1;
      draws_q <= '0;
    end else begin
      draw_q  <= draw_d;
      draws_q <= draws_d;
    end
  end

  assign draws = draws_q;
`else
  logic w_unused_draw_inc;
  assign w_unused_draw_inc = draw_inc;
`endif

endmodule
`default_nettype wire
